mc_fsm_ctrl: RTL

- Multicycle control sequencer for the single-memory-port MIPS datapath.
- Decodes Op/Funct from the IR and steps through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select.
- Adds a memory ready handshake so fetch and load/store can stall for wait-state memory.

---
 rtl/mc_pkg.sv | 88 ++++++++
 rtl/mc_alu_dec.sv | 47 ++++
 rtl/mc_fsm_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation codes, FSM state codes and datapath select encodings.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_SRA = 4'd10;
  localparam logic [3:0] ALU_LUI = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXE    = 4'd6,
    S_ALUWB   = 4'd7,
    S_IEXE    = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_RJR     = 4'd13,
    S_ILLEGAL = 4'd14,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RD1    = 2'd3;

  localparam logic [1:0] GPR_RD  = 2'd0;
  localparam logic [1:0] GPR_RT  = 2'd1;
  localparam logic [1:0] GPR_R31 = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_DATA   = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decode for the multicycle controller: maps Op/Funct to the ALU
// operation, immediate extension mode and shift-amount select. funct_bad
// flags an R-type funct with no ALU meaning (jr is handled by the FSM).
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       shift_sel,
  output logic       funct_bad
);

  // R-type decode by funct, I-type decode by opcode
  always_comb begin
    alu_op    = ALU_NOP;
    ext_op    = 1'b1;
    shift_sel = 1'b0;
    funct_bad = 1'b0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: alu_op = ALU_SUB;
        FN_AND:          alu_op = ALU_AND;
        FN_OR:           alu_op = ALU_OR;
        FN_XOR:          alu_op = ALU_XOR;
        FN_NOR:          alu_op = ALU_NOR;
        FN_SLT:          alu_op = ALU_SLT;
        FN_SLL: begin alu_op = ALU_SLL; shift_sel = 1'b1; end
        FN_SRL: begin alu_op = ALU_SRL; shift_sel = 1'b1; end
        FN_SRA: begin alu_op = ALU_SRA; shift_sel = 1'b1; end
        default: funct_bad = 1'b1;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
        OP_ANDI: begin alu_op = ALU_AND; ext_op = 1'b0; end
        OP_ORI:  begin alu_op = ALU_OR;  ext_op = 1'b0; end
        OP_SLTI: alu_op = ALU_SLT;
        OP_LUI:  alu_op = ALU_LUI;
        default: alu_op = ALU_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mc_fsm_ctrl.sv
// Multicycle control sequencer for the single-memory-port MIPS datapath,
// with a mem_ready handshake that stalls fetch and load/store accesses.
// Build option: MC_FSM_TRAP_EN makes an illegal instruction halt the core
// (sticky until reset) instead of retiring as a NOP.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | pick next state by opcode, precompute branch target
// MEMADR  | compute load/store address
// MEMRD   | load access, waits on mem_ready
// MEMWB   | write loaded data to rt
// MEMWR   | store access, waits on mem_ready
// REXE    | R-type ALU operation
// ALUWB   | write ALU result to rd
// IEXE    | immediate ALU operation
// IWB     | write ALU result to rt
// BRANCH  | compare, conditionally load branch target
// JUMP    | load jump target
// JAL     | load jump target, link PC into r31
// RJR     | load PC from rs
// ILLEGAL | undecodable instruction, one cycle
// HALT    | trapped, only left by reset
module mc_fsm_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               EXTOp,
  output logic [3:0]         ALUOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t     state, state_nxt;
  logic [3:0] dec_alu_op;
  logic       dec_ext_op;
  logic       dec_shift;
  logic       dec_funct_bad;

  mc_alu_dec u_alu_dec (
    .op        (Op),
    .funct     (Funct),
    .alu_op    (dec_alu_op),
    .ext_op    (dec_ext_op),
    .shift_sel (dec_shift),
    .funct_bad (dec_funct_bad)
  );

  assign state_o = STATE_W'(state);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next-state and datapath controls; write enables are forced low in reset
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    EXTOp     = 1'b0;
    ALUOp     = ALU_NOP;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_B;
    PCSource  = PCSRC_ALU;
    GPRSel    = GPR_RD;
    WDSel     = WD_ALUOUT;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_ADD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BOFF;
        ALUOp   = ALU_ADD;
        case (Op)
          OP_RTYPE:                   state_nxt = (Funct == FN_JR) ? S_RJR : S_REXE;
          OP_LW, OP_SW:               state_nxt = S_MEMADR;
          OP_BEQ, OP_BNE:             state_nxt = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_ORI, OP_SLTI, OP_LUI:    state_nxt = S_IEXE;
          OP_J:                       state_nxt = S_JUMP;
          OP_JAL:                     state_nxt = S_JAL;
          default:                    state_nxt = S_ILLEGAL;
        endcase
      end
      S_REXE: begin
        ALUSrcA   = dec_shift ? SRCA_SHAMT : SRCA_A;
        ALUSrcB   = SRCB_B;
        ALUOp     = dec_alu_op;
        state_nxt = dec_funct_bad ? S_ILLEGAL : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        GPRSel    = GPR_RD;
        WDSel     = WD_ALUOUT;
        state_nxt = S_FETCH;
      end
      S_IEXE: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        EXTOp     = dec_ext_op;
        ALUOp     = dec_alu_op;
        state_nxt = S_IWB;
      end
      S_IWB: begin
        RegWrite  = 1'b1;
        GPRSel    = GPR_RT;
        WDSel     = WD_ALUOUT;
        state_nxt = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        EXTOp     = 1'b1;
        ALUOp     = ALU_ADD;
        state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        GPRSel    = GPR_RT;
        WDSel     = WD_DATA;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_B;
        ALUOp     = ALU_SUB;
        PCSource  = PCSRC_ALUOUT;
        PCWrite   = (Op == OP_BNE) ? ~Zero : Zero;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        PCSource  = PCSRC_JUMP;
        PCWrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        PCSource  = PCSRC_JUMP;
        PCWrite   = 1'b1;
        RegWrite  = 1'b1;
        GPRSel    = GPR_R31;
        WDSel     = WD_PC;
        state_nxt = S_FETCH;
      end
      S_RJR: begin
        PCSource  = PCSRC_RD1;
        PCWrite   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
`ifdef MC_FSM_TRAP_EN
        state_nxt = S_HALT;
`else
        state_nxt = S_FETCH;
`endif
      end
      S_HALT: begin
`ifdef MC_FSM_TRAP_EN
        illegal   = 1'b1;
        state_nxt = S_HALT;
`else
        state_nxt = S_FETCH;
`endif
      end
      default: state_nxt = S_FETCH;
    endcase

    if (!rst) begin
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
